// File: rtl/slot_alloc_if.sv
// Handshake and status bundle for the 64-slot allocator.
// master drives requests/releases; slave is the allocator itself.
interface slot_alloc_if #(
  parameter int unsigned IDX_W = 6
);
  logic                    alloc_req;
  logic                    alloc_gnt;
  logic [IDX_W-1:0]        alloc_idx;
  logic                    rel_vld;
  logic [IDX_W-1:0]        rel_idx;
  logic                    flush;
  logic [(1<<IDX_W)-1:0]   busy_mask;
  logic [IDX_W:0]          free_cnt;
  logic                    full;
  logic                    empty;
  logic                    err_dbl_free;
  logic                    err_ovf_req;

  modport master (
    output alloc_req, rel_vld, rel_idx, flush,
    input  alloc_gnt, alloc_idx, busy_mask, free_cnt, full, empty, err_dbl_free, err_ovf_req
  );

  modport slave (
    input  alloc_req, rel_vld, rel_idx, flush,
    output alloc_gnt, alloc_idx, busy_mask, free_cnt, full, empty, err_dbl_free, err_ovf_req
  );
endinterface

// File: rtl/slot_alloc.sv
// Busy/free tracker for 64 slots: grants the lowest free slot same-cycle,
// accepts releases, and keeps occupancy count plus sticky protocol errors.
module slot_alloc #(
  parameter int unsigned                IDX_W      = 6,
  parameter logic [(1<<IDX_W)-1:0]      RESET_BUSY = '0
) (
  input logic          clk,
  input logic          rst,
  slot_alloc_if.slave  bus
);
  localparam int unsigned N = 1 << IDX_W;

  function automatic int unsigned count_ones(input logic [N-1:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < int'(N); i++) begin
      if (v[i]) c++;
    end
    return c;
  endfunction

  localparam logic [IDX_W:0] RESET_FREE = (IDX_W+1)'(N - count_ones(RESET_BUSY));

  logic [N-1:0]     busy_q, busy_d;
  logic [IDX_W:0]   free_q, free_d;
  logic             dbl_q, ovf_q;
  logic [IDX_W-1:0] idx;
  logic             full, gnt, rel_ok, rel_bad;

  // Lowest-index free slot wins; falls back to 0 when nothing is free.
  always_comb begin
    idx = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (!busy_q[i]) idx = IDX_W'(i);
    end
  end

  assign full    = (free_q == '0);
  assign gnt     = bus.alloc_req & ~full;
  assign rel_ok  = bus.rel_vld & busy_q[bus.rel_idx];
  assign rel_bad = bus.rel_vld & ~busy_q[bus.rel_idx];

  // Allocation reads the pre-edge mask, so a same-cycle release is never re-granted.
  always_comb begin
    busy_d = busy_q;
    if (gnt)    busy_d[idx]         = 1'b1;
    if (rel_ok) busy_d[bus.rel_idx] = 1'b0;
    free_d = free_q;
    unique case ({rel_ok, gnt})
      2'b10:   free_d = free_q + 1'b1;
      2'b01:   free_d = free_q - 1'b1;
      default: free_d = free_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= RESET_BUSY;
      free_q <= RESET_FREE;
      dbl_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (bus.flush) begin
      busy_q <= RESET_BUSY;
      free_q <= RESET_FREE;
    end else begin
      busy_q <= busy_d;
      free_q <= free_d;
      if (rel_bad)              dbl_q <= 1'b1;
      if (bus.alloc_req & full) ovf_q <= 1'b1;
    end
  end

  assign bus.alloc_gnt    = gnt;
  assign bus.alloc_idx    = idx;
  assign bus.busy_mask    = busy_q;
  assign bus.free_cnt     = free_q;
  assign bus.full         = full;
  assign bus.empty        = (busy_q == RESET_BUSY);
  assign bus.err_dbl_free = dbl_q;
  assign bus.err_ovf_req  = ovf_q;
endmodule

// File: doc/slot_alloc.md
Name: slot_alloc

Overview:
- Tracks busy/free state of 64 slots and hands out the lowest-numbered free slot as a 6-bit index on request.
- Accepts 6-bit slot releases.
- Sits directly upstream of the 6-to-64 one-hot decoder: alloc_idx drives the decoder input, which generates per-slot write enables.
- Provides occupancy status (count, full, empty) and sticky protocol-error flags.

Parameters:
- IDX_W, 6, index width; slot count N = 2**IDX_W = 64. Only 6 is supported by the downstream decoder.
- RESET_BUSY, 64'h0, busy_mask value loaded on reset; bit i = 1 means slot i is pre-reserved.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- alloc_req  input  1  request one slot this cycle
- alloc_gnt  output  1  combinational; alloc_req & ~full
- alloc_idx  output  6  combinational; lowest-numbered free slot; 6'h00 when full
- rel_vld  input  1  release slot rel_idx this cycle
- rel_idx  input  6  slot to release
- flush  input  1  free all slots, except RESET_BUSY slots, which stay busy
- busy_mask  output  64  registered busy bits; bit i = slot i
- free_cnt  output  7  registered count of free slots, 0..64
- full  output  1  combinational; free_cnt == 0
- empty  output  1  combinational; busy_mask == RESET_BUSY
- err_dbl_free  output  1  sticky; set when a free slot is released
- err_ovf_req  output  1  sticky; set when alloc_req is asserted while full

Behaviour:
- Reset (rst=1 at edge), highest priority:
  - busy_mask <= RESET_BUSY
  - free_cnt <= 64 - popcount(RESET_BUSY), elaborated constant
  - both error flags <= 0
- Reset mid-operation: discards all pending requests that cycle. No grant takes effect and no error is flagged.
- Flush (rst=0, flush=1):
  - busy_mask <= RESET_BUSY; free_cnt <= reset value
  - Any alloc and release in the same cycle are ignored; alloc_gnt is still driven combinationally but has no state effect.
  - Error flags are held.
- Allocation:
  - alloc_idx = index of the least-significant 0 in the current (pre-edge) busy_mask.
  - On the edge with alloc_gnt=1: busy_mask[alloc_idx] <= 1.
  - Grant is same-cycle (0 latency); the index is consumed by the decoder in that cycle.
- Release:
  - rel_vld=1 and busy_mask[rel_idx]=1: busy_mask[rel_idx] <= 0.
  - rel_vld=1 and busy_mask[rel_idx]=0: double free. No state change; err_dbl_free <= 1.
- Simultaneous alloc + release:
  - Both apply at the same edge.
  - Allocation selects from the pre-edge mask. A slot released this cycle is not re-granted until the next cycle (no bypass).
  - Net free_cnt change = (valid release ? +1 : 0) - (alloc_gnt ? 1 : 0).
  - Release of a slot that is busy pre-edge can never collide with alloc_idx, because alloc_idx is always a free slot.
- Full:
  - alloc_gnt=0 and alloc_idx=0.
  - alloc_req while full sets err_ovf_req, with no state change.
  - A release in the same cycle is still honoured; the freed slot becomes grantable next cycle.
- free_cnt never wraps. Invariant: free_cnt == 64 - popcount(busy_mask) in every cycle after reset.
- Error flags clear only on rst.
- Priority encoder is a pure function of busy_mask (64-to-6, lowest index wins). No round-robin or pointer state.

Test Plan:
- Reset, RESET_BUSY=0 -> busy_mask=0, free_cnt=64, empty=1, full=0, alloc_idx=0, errors=0.
- 64 back-to-back alloc_req cycles -> alloc_idx runs 0,1,...,63; after the 64th edge: full=1, free_cnt=0, busy_mask=all ones. A 65th request -> alloc_gnt=0, err_ovf_req=1 next cycle.
- From full: release idx 5, then alloc -> alloc_idx=5, free_cnt returns to 0; release idx 5 twice with no re-alloc -> second release sets err_dbl_free, free_cnt stays 1.
- Slots 0..3 busy: same cycle alloc_req=1, rel_vld=1, rel_idx=1 -> grant idx 4 (not 1), free_cnt unchanged at 60; next cycle alloc -> idx 1.
- RESET_BUSY=64'hF: reset -> free_cnt=60, alloc_idx=4. Allocate 10 slots, then flush -> busy_mask=64'hF, free_cnt=60, empty=1.
- Assert rst mid-sequence with alloc_req=1 and rel_vld=1 -> reset values next cycle; no error flags set.
